// File: rtl/reg_port_master.sv
// Issue-side initiator for the 8-bit register file: operand fetch with writeback
// bypass, a pending-write scoreboard for RAW/WAW stalls, and a one-entry operand stage.
module reg_port_master #(
  parameter int unsigned DW    = 8,
  parameter int unsigned AW    = 5,
  parameter int unsigned NREGS = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             iss_valid,
  output logic             iss_ready,
  input  logic [AW-1:0]    iss_rs1,
  input  logic [AW-1:0]    iss_rs2,
  input  logic [AW-1:0]    iss_rd,
  input  logic             iss_wr,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [DW-1:0]    op_a,
  output logic [DW-1:0]    op_b,
  output logic [AW-1:0]    op_rd,
  output logic             op_wr,
  input  logic             wb_valid,
  input  logic [AW-1:0]    wb_rd,
  input  logic [DW-1:0]    wb_data,
  output logic [7:0]       rf_a1,
  output logic [7:0]       rf_a2,
  output logic             rf_re,
  input  logic [DW-1:0]    rf_rd1,
  input  logic [DW-1:0]    rf_rd2,
  output logic [7:0]       rf_a3,
  output logic [DW-1:0]    rf_wdata,
  output logic             rf_we,
  output logic [NREGS-1:0] busy_mask,
  output logic [7:0]       stall_cnt,
  output logic             err_wb
);

  localparam int unsigned RFAW = 8;
  localparam int unsigned CNTW = 8;
  localparam logic [CNTW-1:0] CNT_MAX = '1;

  typedef enum logic {RUN, STALL} state_t;

  state_t            state_q, state_d;
  logic              op_valid_q, op_valid_d;
  logic [DW-1:0]     op_a_q, op_a_d, op_b_q, op_b_d;
  logic [AW-1:0]     op_rd_q, op_rd_d;
  logic              op_wr_q, op_wr_d;
  logic [NREGS-1:0]  busy_q, busy_d;
  logic [CNTW-1:0]   stall_cnt_q, stall_cnt_d;
  logic              err_wb_q, err_wb_d;

  logic clr_rs1, clr_rs2, clr_rd, hazard, accept, ready;

  // File ports follow their sources directly so the file writes on the same edge
  assign rf_a1    = RFAW'(iss_rs1);
  assign rf_a2    = RFAW'(iss_rs2);
  assign rf_re    = iss_valid;
  assign rf_a3    = RFAW'(wb_rd);
  assign rf_wdata = wb_data;
  assign rf_we    = wb_valid;

  assign op_valid  = op_valid_q;
  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign op_rd     = op_rd_q;
  assign op_wr     = op_wr_q;
  assign busy_mask = busy_q;
  assign stall_cnt = stall_cnt_q;
  assign err_wb    = err_wb_q;
  assign iss_ready = ready;

  always_comb begin
    clr_rs1 = 1'b0;
    clr_rs2 = 1'b0;
    clr_rd  = 1'b0;
    hazard  = 1'b0;
    ready   = 1'b0;
    accept  = 1'b0;
    clr_rs1 = wb_valid && (wb_rd == iss_rs1);
    clr_rs2 = wb_valid && (wb_rd == iss_rs2);
    clr_rd  = wb_valid && (wb_rd == iss_rd);
    // A writeback landing this edge resolves the hazard through the bypass
    hazard  = (busy_q[iss_rs1] && !clr_rs1) ||
              (busy_q[iss_rs2] && !clr_rs2) ||
              (iss_wr && busy_q[iss_rd] && !clr_rd);
    ready   = rst_n && !hazard && (!op_valid_q || op_ready);
    accept  = iss_valid && ready;
  end

  always_comb begin
    state_d     = state_q;
    op_valid_d  = op_valid_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_rd_d     = op_rd_q;
    op_wr_d     = op_wr_q;
    busy_d      = busy_q;
    stall_cnt_d = stall_cnt_q;
    err_wb_d    = err_wb_q;

    case (state_q)
      RUN:     if (iss_valid && hazard) state_d = STALL;
      STALL:   if (!iss_valid || !hazard) state_d = RUN;
      default: state_d = RUN;
    endcase

    if (state_q == STALL && iss_valid && stall_cnt_q != CNT_MAX)
      stall_cnt_d = stall_cnt_q + CNTW'(1);

    if (accept) begin
      op_valid_d = 1'b1;
      op_a_d     = clr_rs1 ? wb_data : rf_rd1;
      op_b_d     = clr_rs2 ? wb_data : rf_rd2;
      op_rd_d    = iss_rd;
      op_wr_d    = iss_wr;
    end else if (op_ready) begin
      op_valid_d = 1'b0;
    end

    // Clear first so a same-edge set of the same register wins
    if (wb_valid) begin
      if (!busy_q[wb_rd]) err_wb_d = 1'b1;
      busy_d[wb_rd] = 1'b0;
    end
    if (accept && iss_wr) busy_d[iss_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      op_valid_q  <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_rd_q     <= '0;
      op_wr_q     <= 1'b0;
      busy_q      <= '0;
      stall_cnt_q <= '0;
      err_wb_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_valid_q  <= op_valid_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_rd_q     <= op_rd_d;
      op_wr_q     <= op_wr_d;
      busy_q      <= busy_d;
      stall_cnt_q <= stall_cnt_d;
      err_wb_q    <= err_wb_d;
    end
  end

endmodule

// File: tb/tb_reg_port_master.sv
// Directed bench for reg_port_master with a small behavioural register file
// attached to the rf_* ports.
module tb_reg_port_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iss_valid, iss_ready, iss_wr;
  logic [4:0]  iss_rs1, iss_rs2, iss_rd;
  logic        op_valid, op_ready, op_wr;
  logic [7:0]  op_a, op_b;
  logic [4:0]  op_rd;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [7:0]  wb_data;
  logic [7:0]  rf_a1, rf_a2, rf_a3, rf_wdata, rf_rd1, rf_rd2;
  logic        rf_re, rf_we;
  logic [31:0] busy_mask;
  logic [7:0]  stall_cnt;
  logic        err_wb;

  logic        pre_we;
  logic [4:0]  pre_a;
  logic [7:0]  pre_d;
  logic [7:0]  rf [32];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  reg_port_master dut (
    .clk(clk), .rst_n(rst_n),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd), .iss_wr(iss_wr),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .op_rd(op_rd), .op_wr(op_wr),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_re(rf_re),
    .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .rf_a3(rf_a3), .rf_wdata(rf_wdata), .rf_we(rf_we),
    .busy_mask(busy_mask), .stall_cnt(stall_cnt), .err_wb(err_wb)
  );

  // Register file: combinational read, write on the rising edge
  always @(posedge clk) begin
    if (rf_we) rf[rf_a3[4:0]] <= rf_wdata;
    else if (pre_we) rf[pre_a] <= pre_d;
  end
  assign rf_rd1 = rf[rf_a1[4:0]];
  assign rf_rd2 = rf[rf_a2[4:0]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic wr);
    iss_valid = 1'b1;
    iss_rs1   = rs1;
    iss_rs2   = rs2;
    iss_rd    = rd;
    iss_wr    = wr;
  endtask

  initial begin
    rst_n = 1'b0;
    iss_valid = 1'b0; iss_rs1 = '0; iss_rs2 = '0; iss_rd = '0; iss_wr = 1'b0;
    op_ready = 1'b0; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    pre_we = 1'b1; pre_a = 5'd3; pre_d = 8'h11;
    step();
    pre_a = 5'd4; pre_d = 8'h22;
    step();
    pre_we = 1'b0;

    check("rst_op_valid", 32'(op_valid), 32'd0);
    check("rst_op_a", 32'(op_a), 32'd0);
    check("rst_busy", busy_mask, 32'd0);
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    check("rst_err_wb", 32'(err_wb), 32'd0);
    iss_valid = 1'b1;
    #1;
    check("rst_iss_ready", 32'(iss_ready), 32'd0);
    check("rst_rf_re", 32'(rf_re), 32'd1);
    iss_valid = 1'b0;
    #1 rst_n = 1'b1;
    step();

    // Test 1: plain issue with writeback pending on rd=5
    op_ready = 1'b1;
    issue(5'd3, 5'd4, 5'd5, 1'b1);
    #1;
    check("t1_iss_ready", 32'(iss_ready), 32'd1);
    check("t1_rf_a1", 32'(rf_a1), 32'd3);
    check("t1_rf_a2", 32'(rf_a2), 32'd4);
    step();
    check("t1_op_valid", 32'(op_valid), 32'd1);
    check("t1_op_a", 32'(op_a), 32'h11);
    check("t1_op_b", 32'(op_b), 32'h22);
    check("t1_op_rd", 32'(op_rd), 32'd5);
    check("t1_op_wr", 32'(op_wr), 32'd1);
    check("t1_busy", busy_mask, 32'h20);

    // Test 2: RAW on r5 stalls until writeback, which is bypassed
    issue(5'd5, 5'd0, 5'd0, 1'b0);
    #1;
    check("t2_iss_ready_hz", 32'(iss_ready), 32'd0);
    step();
    check("t2_stall_cnt0", 32'(stall_cnt), 32'd0);
    step();
    step();
    check("t2_stall_cnt2", 32'(stall_cnt), 32'd2);
    check("t2_op_valid_drained", 32'(op_valid), 32'd0);
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 8'h7E;
    #1;
    check("t2_iss_ready_wb", 32'(iss_ready), 32'd1);
    check("t2_rf_we", 32'(rf_we), 32'd1);
    check("t2_rf_a3", 32'(rf_a3), 32'd5);
    check("t2_rf_wdata", 32'(rf_wdata), 32'h7E);
    step();
    wb_valid = 1'b0;
    check("t2_op_a_bypass", 32'(op_a), 32'h7E);
    check("t2_op_valid", 32'(op_valid), 32'd1);
    check("t2_busy", busy_mask, 32'd0);
    check("t2_stall_cnt3", 32'(stall_cnt), 32'd3);
    check("t2_err_wb", 32'(err_wb), 32'd0);

    // Test 3: output backpressure blocks issue without counting a stall
    op_ready = 1'b0;
    issue(5'd3, 5'd4, 5'd6, 1'b1);
    #1;
    check("t3_iss_ready_bp", 32'(iss_ready), 32'd0);
    step();
    step();
    check("t3_op_a_hold", 32'(op_a), 32'h7E);
    check("t3_op_valid_hold", 32'(op_valid), 32'd1);
    check("t3_stall_cnt", 32'(stall_cnt), 32'd3);
    check("t3_busy_hold", busy_mask, 32'd0);
    op_ready = 1'b1;
    #1;
    check("t3_iss_ready_rel", 32'(iss_ready), 32'd1);
    step();
    iss_valid = 1'b0;
    check("t3_op_valid", 32'(op_valid), 32'd1);
    check("t3_op_a", 32'(op_a), 32'h11);
    check("t3_op_b", 32'(op_b), 32'h22);
    check("t3_op_rd", 32'(op_rd), 32'd6);
    check("t3_busy", busy_mask, 32'h40);
    step();
    check("t3_op_valid_drain", 32'(op_valid), 32'd0);

    // Test 4: same-edge set/clear of r7, then writeback to idle r9
    issue(5'd0, 5'd0, 5'd7, 1'b1);
    step();
    check("t4_busy_set7", busy_mask, 32'hC0);
    issue(5'd0, 5'd0, 5'd7, 1'b1);
    wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 8'h33;
    #1;
    check("t4_iss_ready_waw", 32'(iss_ready), 32'd1);
    step();
    check("t4_busy_setwins", busy_mask, 32'hC0);
    check("t4_err_wb0", 32'(err_wb), 32'd0);
    iss_valid = 1'b0;
    wb_rd = 5'd9; wb_data = 8'h5A;
    step();
    wb_valid = 1'b0;
    check("t4_err_wb1", 32'(err_wb), 32'd1);
    check("t4_r9_written", 32'(rf[9]), 32'h5A);
    check("t4_busy_after", busy_mask, 32'hC0);
    issue(5'd9, 5'd5, 5'd0, 1'b0);
    step();
    check("t4_op_a_r9", 32'(op_a), 32'h5A);
    check("t4_op_b_r5", 32'(op_b), 32'h7E);
    check("t4_op_wr", 32'(op_wr), 32'd0);

    // Test 5: long hazard saturates stall_cnt, then async reset mid-run
    op_ready = 1'b0;
    issue(5'd6, 5'd0, 5'd0, 1'b0);
    for (int i = 0; i < 300; i++) step();
    check("t5_stall_sat", 32'(stall_cnt), 32'd255);
    check("t5_op_valid_held", 32'(op_valid), 32'd1);
    check("t5_err_sticky", 32'(err_wb), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_arst_op_valid", 32'(op_valid), 32'd0);
    check("t5_arst_busy", busy_mask, 32'd0);
    check("t5_arst_stall", 32'(stall_cnt), 32'd0);
    check("t5_arst_err", 32'(err_wb), 32'd0);
    check("t5_arst_iss_ready", 32'(iss_ready), 32'd0);
    step();
    rst_n = 1'b1;
    iss_valid = 1'b0;
    step();
    check("t5_post_busy", busy_mask, 32'd0);
    check("t5_post_op_valid", 32'(op_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
